// File: rtl/ad9228_core.sv
// ad9228_core: single-channel deserializer for the AD9228 serial LVDS stream.
// The serial data, frame clock and DDR bit clock are oversampled on the
// fabric clock. Every dco transition delivers one bit, MSB first, and fco
// frames each word: high for the first half of the bits, low for the rest.
//
// Interface contract: there is no ready/valid back-pressure. read_complete is
// a one-cycle valid strobe that qualifies des_data, and des_data holds its
// value until the next strobe. The consumer must accept the word in the cycle
// read_complete is high.
//
// Debug visibility: the FSM state is held in the 'state' signal, using the
// ST_* encodings below, so that checkers can bind to it.

module ad9228_core #(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  din,
  input  logic                  fco,
  input  logic                  dco,
  output logic [DATA_WIDTH-1:0] des_data,
  output logic                  read_complete
);

  localparam int HALF  = DATA_WIDTH / 2;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  // FSM encodings. ST_DONE is the single cycle in which a completed word is
  // published.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] din_sr;
  logic [SYNC_STAGES-1:0] fco_sr;
  logic [SYNC_STAGES-1:0] dco_sr;
  logic                   din_sync;
  logic                   fco_sync;
  logic                   dco_sync;
  logic                   dco_prev;
  logic                   fco_last;
  logic                   bit_evt;
  logic                   fco_rise;
  logic                   fco_exp;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  shift_nxt;

  // Bring the three asynchronous pins into the clk domain. All three pins use
  // the same depth so that din and fco stay aligned with the dco edge they
  // belong to.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      din_sr <= '0;
      fco_sr <= '0;
      dco_sr <= '0;
    end else begin
      din_sr <= {din_sr[SYNC_STAGES-2:0], din};
      fco_sr <= {fco_sr[SYNC_STAGES-2:0], fco};
      dco_sr <= {dco_sr[SYNC_STAGES-2:0], dco};
    end
  end

  assign din_sync = din_sr[SYNC_STAGES-1];
  assign fco_sync = fco_sr[SYNC_STAGES-1];
  assign dco_sync = dco_sr[SYNC_STAGES-1];

  // Track the dco history, which is used to detect either edge. Also track the
  // fco level seen at the previous bit, which is used to detect a frame start.
  // fco_last resets to 0, so the first bit after reset counts as a rise when
  // fco is high.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      dco_prev <= 1'b0;
      fco_last <= 1'b0;
    end else begin
      dco_prev <= dco_sync;
      if (bit_evt) begin
        fco_last <= fco_sync;
      end
    end
  end

  assign bit_evt  = dco_sync ^ dco_prev;
  assign fco_rise = fco_sync & ~fco_last;
  // bit_cnt holds the number of bits already captured. That number is also
  // the index of the bit that arrives next.
  assign fco_exp  = (bit_cnt < CNT_HALF);

  // Next-state logic. It covers frame start, shifting, frame checking against
  // fco, and completion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    case (state)
      ST_IDLE: begin
        if (bit_evt && fco_rise) begin
          shift_nxt = {{(DATA_WIDTH-1){1'b0}}, din_sync};
          cnt_nxt   = CNT_ONE;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_evt) begin
          if (fco_sync == fco_exp) begin
            shift_nxt = {shift_reg[DATA_WIDTH-2:0], din_sync};
            cnt_nxt   = bit_cnt + CNT_ONE;
            if (bit_cnt == CNT_LAST) begin
              state_nxt = ST_DONE;
            end
          end else if (fco_rise) begin
            // A misplaced fco rise abandons the partial word and starts a
            // new frame with this bit.
            shift_nxt = {{(DATA_WIDTH-1){1'b0}}, din_sync};
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register the FSM state, the bit counter and the shift register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Publish the word one cycle after its final bit is captured. des_data only
  // changes together with the strobe, so it never shows a partial word.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      des_data      <= '0;
      read_complete <= 1'b0;
    end else begin
      read_complete <= (state == ST_DONE);
      if (state == ST_DONE) begin
        des_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_ad9228_core.sv
// Testbench for ad9228_core. A directed sequence is followed by randomized
// frames. Expected words come from a sliding-window model of the serial
// stream: a word is valid when its DATA_WIDTH fco samples read as half ones,
// then half zeros, and the fco sample just before the window is low.

module tb_ad9228_core;

  localparam int DW   = 12;
  localparam int HALF = DW / 2;

  logic          clk;
  logic          rstn;
  logic          din;
  logic          fco;
  logic          dco;
  logic [DW-1:0] des_data;
  logic          read_complete;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int exp_total = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  bit            din_h[$];
  bit            fco_h[$];

  logic [DW-1:0] exp_des;
  bit            prev_rc;

  ad9228_core #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .din           (din),
    .fco           (fco),
    .dco           (dco),
    .des_data      (des_data),
    .read_complete (read_complete)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a sliding window over the bit stream since the last reset
  function automatic void model_reset();
    din_h.delete();
    fco_h.delete();
    din_h.push_back(1'b0);
    fco_h.push_back(1'b0);
  endfunction

  function automatic void model_bit(bit d, bit f);
    bit            ok;
    logic [DW-1:0] w;
    din_h.push_back(d);
    fco_h.push_back(f);
    while (fco_h.size() > DW + 1) begin
      void'(fco_h.pop_front());
      void'(din_h.pop_front());
    end
    if (fco_h.size() == DW + 1) begin
      ok = (fco_h[0] == 1'b0);
      w  = '0;
      for (int i = 1; i <= DW; i++) begin
        if (fco_h[i] != (i <= HALF)) ok = 1'b0;
        w = {w[DW-2:0], din_h[i]};
      end
      if (ok) begin
        exp_q.push_back(w);
        exp_cyc_q.push_back(cyc);
        exp_total++;
      end
    end
  endfunction

  // Driver tasks
  task automatic send_bit(input bit d, input bit f, input int period);
    @(posedge clk); #1;
    din = d;
    fco = f;
    dco = ~dco;
    model_bit(d, f);
    repeat (period - 1) @(posedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int period);
    for (int i = 0; i < DW; i++) send_bit(w[DW-1-i], (i < HALF), period);
  endtask

  // Sends DW bits of w, with fco high for the first k_high bits only.
  task automatic send_broken(input logic [DW-1:0] w, input int k_high, input int period);
    for (int i = 0; i < DW; i++) send_bit(w[DW-1-i], (i < k_high), period);
  endtask

  task automatic do_reset(input int n, input bit rand_pins);
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      if (rand_pins) begin
        din = 1'($urandom_range(0, 1));
        fco = 1'($urandom_range(0, 1));
        dco = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    din = 1'b0;
    fco = 1'b0;
    dco = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
  endtask

  // Scoreboard: checks every strobe against the model, checks its latency,
  // and checks that des_data holds between strobes.
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      assert (read_complete === 1'b0 && des_data === '0) else begin
        errors++;
        $error("FAIL reset_out: rc=%b data=%h exp rc=0 data=000", read_complete, des_data);
      end
      exp_des = '0;
      prev_rc = 1'b0;
    end else if (read_complete === 1'b1) begin
      pulse_cnt++;
      checks++;
      assert (prev_rc == 1'b0) else begin
        errors++;
        $error("FAIL pulse_width: rc high two cycles in a row, exp single cycle");
      end
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL extra_pulse: data=%h with no word expected", des_data);
      end
      if (exp_q.size() > 0) begin
        logic [DW-1:0] w;
        int            c;
        w = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        checks++;
        assert (des_data === w) else begin
          errors++;
          $error("FAIL word: got %h exp %h", des_data, w);
        end
        checks++;
        assert ((cyc - c) >= 3 && (cyc - c) <= 5) else begin
          errors++;
          $error("FAIL latency: got %0d cycles exp 3..5", cyc - c);
        end
        exp_des = w;
      end
      prev_rc = 1'b1;
    end else begin
      checks++;
      assert (read_complete === 1'b0 && des_data === exp_des) else begin
        errors++;
        $error("FAIL hold: rc=%b data=%h exp rc=0 data=%h", read_complete, des_data, exp_des);
      end
      prev_rc = 1'b0;
    end
  end

  // Directed steps, then randomized frames
  initial begin
    int            p_before;
    int            period;
    int            kind;
    logic [DW-1:0] w;

    rstn = 1'b1;
    din  = 1'b0;
    fco  = 1'b0;
    dco  = 1'b0;
    model_reset();

    // Reset with random pin activity
    do_reset(2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (read_complete === 1'b0 && des_data === 12'h000) else begin
      errors++;
      $error("FAIL post_reset: rc=%b data=%h exp 0/000", read_complete, des_data);
    end

    // Single frame
    send_word(12'h7FF, 6);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    assert (pulse_cnt == 1 && des_data === 12'h7FF) else begin
      errors++;
      $error("FAIL single: pulses=%0d data=%h exp 1/7ff", pulse_cnt, des_data);
    end

    // Back-to-back frames
    send_word(12'hA5C, 6);
    send_word(12'h3F0, 6);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    assert (pulse_cnt == 3 && des_data === 12'h3F0) else begin
      errors++;
      $error("FAIL b2b: pulses=%0d data=%h exp 3/3f0", pulse_cnt, des_data);
    end

    // Frame error: fco drops after 4 bits, then a good frame
    send_broken(12'hFAB, 4, 6);
    send_word(12'h123, 6);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    assert (pulse_cnt == 4 && des_data === 12'h123) else begin
      errors++;
      $error("FAIL frame_err: pulses=%0d data=%h exp 4/123", pulse_cnt, des_data);
    end

    // Reset mid-frame after 7 bits of 0xFFF
    for (int i = 0; i < 7; i++) send_bit(1'b1, (i < HALF), 6);
    do_reset(2, 1'b0);
    #1;
    checks++;
    assert (des_data === 12'h000) else begin
      errors++;
      $error("FAIL mid_reset: data=%h exp 000", des_data);
    end
    send_word(12'h001, 6);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    assert (pulse_cnt == 5 && des_data === 12'h001) else begin
      errors++;
      $error("FAIL after_reset: pulses=%0d data=%h exp 5/001", pulse_cnt, des_data);
    end

    // Idle dco and fco
    p_before = pulse_cnt;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    assert (pulse_cnt == p_before && des_data === 12'h001) else begin
      errors++;
      $error("FAIL idle: pulses=%0d data=%h exp %0d/001", pulse_cnt, des_data, p_before);
    end

    // Randomized mix of good frames, broken frames, gap bits and idle time
    for (int n = 0; n < 60; n++) begin
      period = $urandom_range(3, 7);
      kind   = $urandom_range(0, 4);
      w      = DW'($urandom);
      case (kind)
        0, 1:    send_word(w, period);
        2:       send_broken(w, $urandom_range(1, HALF - 1), period);
        3:       send_broken(w, $urandom_range(HALF + 1, DW), period);
        default: begin
          for (int g = 0; g < int'($urandom_range(1, 4)); g++)
            send_bit(1'($urandom_range(0, 1)), 1'b0, period);
        end
      endcase
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 0 && pulse_cnt == exp_total) else begin
      errors++;
      $error("FAIL drain: pulses=%0d exp %0d pending=%0d", pulse_cnt, exp_total, exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
